// File: rtl/reg_file_if.sv
// ----------------------------------------------------------------------------
// reg_file_if
// Purpose : Bundles the write, read and clear signals of reg_file into one
//           interface so the register file and its user share a single port.
// Params  : WIDTH - data bits per entry
//           DEPTH - number of entries (need not be a power of two)
// Signals : clr      - synchronous clear of all entries
//           we       - write enable
//           waddr    - write address (AW bits)
//           wdata    - write data (WIDTH bits)
//           re_a     - read enable, port A
//           raddr_a  - read address, port A
//           rdata_a  - registered read data, port A
//           re_b     - read enable, port B
//           raddr_b  - read address, port B
//           rdata_b  - registered read data, port B
//           rvalid   - bit0/bit1: port A/B data was updated by a read last cycle
// Modports: master drives requests and receives data; slave is the register file.
// ----------------------------------------------------------------------------
interface reg_file_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic             clr;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             re_a;
    logic [AW-1:0]    raddr_a;
    logic [WIDTH-1:0] rdata_a;
    logic             re_b;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_b;
    logic [1:0]       rvalid;

    modport master (
        output clr, we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
        input  rdata_a, rdata_b, rvalid
    );

    modport slave (
        input  clr, we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
        output rdata_a, rdata_b, rvalid
    );
endinterface

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
// Purpose : DEPTH x WIDTH register file with one write port, two independent
//           registered read ports (latency 1) and a synchronous clear.
// Ports   : clk   - sole clock, all state changes on its rising edge
//           rst_n - asynchronous active-low reset; clears entries and read regs
//           bus   - reg_file_if.slave (clr, we, waddr, wdata, re_a/raddr_a,
//                   re_b/raddr_b in; rdata_a, rdata_b, rvalid out)
// Params  : WIDTH, DEPTH must match the parameters of the connected interface.
// Config  : REG_FILE_BYPASS_EN - when defined, a read in the same cycle as a
//           write to the same entry returns the new write data, and a read in
//           the same cycle as clr returns 0. When undefined, reads return the
//           contents held before that edge. Storage behaviour is identical.
// Out-of-range addresses (>= DEPTH) never write and read back as zero.
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module reg_file #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_file_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata_a;
    logic [WIDTH-1:0] r_rdata_b;
    logic [1:0]       r_rvalid;

    logic [DEPTH-1:0] w_wsel;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // One-hot write select. An address >= DEPTH matches no entry, so such
    // writes are dropped; clr suppresses the write entirely.
    always_comb begin
        w_wsel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.we && !bus.clr && (bus.waddr == AW'(i))) begin
                w_wsel[i] = 1'b1;
            end
        end
    end

    // Read muxes built as a compare loop so out-of-range addresses fall
    // through to the zero default instead of indexing past the array.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.raddr_a == AW'(i)) begin
                w_rd_a = r_mem[i];
            end
            if (bus.raddr_b == AW'(i)) begin
                w_rd_b = r_mem[i];
            end
        end
`ifdef REG_FILE_BYPASS_EN
        // w_wsel is non-zero only for an in-range write without clr, so it
        // doubles as the forwarding qualifier.
        if (bus.clr) begin
            w_rd_a = '0;
            w_rd_b = '0;
        end else begin
            if ((|w_wsel) && (bus.waddr == bus.raddr_a)) begin
                w_rd_a = bus.wdata;
            end
            if ((|w_wsel) && (bus.waddr == bus.raddr_b)) begin
                w_rd_b = bus.wdata;
            end
        end
`endif
    end

    // Entry storage: clr has priority over any write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wsel[i]) begin
                    r_mem[i] <= bus.wdata;
                end
            end
        end
    end

    // Read registers hold their value while the port is idle; rvalid marks
    // the cycle right after an accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
            r_rvalid  <= 2'b00;
        end else begin
            r_rvalid <= {bus.re_b, bus.re_a};
            if (bus.re_a) begin
                r_rdata_a <= w_rd_a;
            end
            if (bus.re_b) begin
                r_rdata_b <= w_rd_b;
            end
        end
    end

    assign bus.rdata_a = r_rdata_a;
    assign bus.rdata_b = r_rdata_b;
    assign bus.rvalid  = r_rvalid;

endmodule

// File: tb/tb_reg_file.sv
// ----------------------------------------------------------------------------
// tb_reg_file
// Purpose : Directed scoreboard bench for reg_file (WIDTH=8, DEPTH=5 so that
//           out-of-range addresses 5..7 exist). Stimulus pushes hand-computed
//           read results into per-port queues; a monitor pops and compares
//           them whenever the DUT should present read data.
// Config  : expectations for same-cycle write/clear follow REG_FILE_BYPASS_EN.
// ----------------------------------------------------------------------------
module tb_reg_file;
    localparam int WIDTH = 8;
    localparam int DEPTH = 5;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    logic [7:0] expA [$];
    logic [7:0] expB [$];

    reg_file_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point shared by the monitor and direct checks.
    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic driveIdle();
        bus.clr     = 1'b0;
        bus.we      = 1'b0;
        bus.waddr   = '0;
        bus.wdata   = '0;
        bus.re_a    = 1'b0;
        bus.raddr_a = '0;
        bus.re_b    = 1'b0;
        bus.raddr_b = '0;
    endtask

    // Drives one cycle of inputs on the falling edge and records the read
    // data each enabled port must show after the next rising edge.
    task automatic applyStimulus(input logic c, input logic w, input logic [2:0] wa,
                                 input logic [7:0] wd,
                                 input logic ra, input logic [2:0] aa, input logic [7:0] ea,
                                 input logic rb, input logic [2:0] ab, input logic [7:0] eb);
        @(negedge clk);
        bus.clr     = c;
        bus.we      = w;
        bus.waddr   = wa;
        bus.wdata   = wd;
        bus.re_a    = ra;
        bus.raddr_a = aa;
        bus.re_b    = rb;
        bus.raddr_b = ab;
        if (ra) expA.push_back(ea);
        if (rb) expB.push_back(eb);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00);
    endtask

    task automatic writeEntry(input logic [2:0] wa, input logic [7:0] wd);
        applyStimulus(0, 1, wa, wd, 0, 0, 8'h00, 0, 0, 8'h00);
    endtask

    task automatic readPair(input logic [2:0] aa, input logic [7:0] ea,
                            input logic [2:0] ab, input logic [7:0] eb);
        applyStimulus(0, 0, 0, 8'h00, 1, aa, ea, 1, ab, eb);
    endtask

    // Monitor: 2 time units after each rising edge, rvalid must be set exactly
    // when an expectation is queued, and then the data must match it.
    always @(posedge clk) begin
        logic [7:0] e;
        #2;
        if (rst_n) begin
            checkOutput("rvalid_a", {7'b0, bus.rvalid[0]}, {7'b0, (expA.size() != 0)});
            if (expA.size() != 0) begin
                e = expA.pop_front();
                if (bus.rvalid[0]) checkOutput("rdata_a", bus.rdata_a, e);
            end
            checkOutput("rvalid_b", {7'b0, bus.rvalid[1]}, {7'b0, (expB.size() != 0)});
            if (expB.size() != 0) begin
                e = expB.pop_front();
                if (bus.rvalid[1]) checkOutput("rdata_b", bus.rdata_b, e);
            end
        end
    end

    initial begin
        driveIdle();
        rst_n = 1'b0;
        #3;
        checkOutput("reset_rdata_a", bus.rdata_a, 8'h00);
        checkOutput("reset_rdata_b", bus.rdata_b, 8'h00);
        checkOutput("reset_rvalid", {6'b0, bus.rvalid}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read on port A only.
        writeEntry(3'd2, 8'hA5);
        applyStimulus(0, 0, 0, 8'h00, 1, 3'd2, 8'hA5, 0, 0, 8'h00);

        // Populate remaining entries.
        writeEntry(3'd0, 8'h42);
        writeEntry(3'd1, 8'h11);
        writeEntry(3'd3, 8'h99);
        writeEntry(3'd4, 8'h07);

        // Dual read of different entries.
        readPair(3'd0, 8'h42, 3'd3, 8'h99);

        // Read-during-write on port B: forwarded with bypass, old value without.
        applyStimulus(0, 1, 3'd1, 8'h3C, 0, 0, 8'h00, 1, 3'd1, BYP ? 8'h3C : 8'h11);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 3'd1, 8'h3C);

        // Both ports on the same entry, then rdata must hold while idle.
        readPair(3'd4, 8'h07, 3'd4, 8'h07);
        idleCycle();
        idleCycle();
        @(posedge clk);
        #3;
        checkOutput("hold_rdata_a", bus.rdata_a, 8'h07);
        checkOutput("hold_rdata_b", bus.rdata_b, 8'h07);

        // Out-of-range write is ignored; out-of-range reads return zero.
        writeEntry(3'd7, 8'hFF);
        readPair(3'd7, 8'h00, 3'd5, 8'h00);
        readPair(3'd0, 8'h42, 3'd1, 8'h3C);
        readPair(3'd2, 8'hA5, 3'd3, 8'h99);
        readPair(3'd4, 8'h07, 3'd6, 8'h00);

        // Clear beats a simultaneous write; same-cycle reads follow the build.
        for (int i = 0; i < DEPTH; i++) writeEntry(3'(i), 8'h5A);
        applyStimulus(1, 1, 3'd0, 8'h77, 1, 3'd0, BYP ? 8'h00 : 8'h5A,
                      1, 3'd2, BYP ? 8'h00 : 8'h5A);
        readPair(3'd0, 8'h00, 3'd1, 8'h00);
        readPair(3'd2, 8'h00, 3'd3, 8'h00);
        readPair(3'd4, 8'h00, 3'd0, 8'h00);

        // Asynchronous reset in the middle of a cycle with live read data.
        writeEntry(3'd3, 8'hC3);
        readPair(3'd3, 8'hC3, 3'd3, 8'hC3);
        @(posedge clk);
        #3;
        driveIdle();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_rdata_a", bus.rdata_a, 8'h00);
        checkOutput("midrst_rdata_b", bus.rdata_b, 8'h00);
        checkOutput("midrst_rvalid", {6'b0, bus.rvalid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        readPair(3'd3, 8'h00, 3'd2, 8'h00);

        idleCycle();
        idleCycle();
        @(posedge clk);
        #3;
        checkOutput("scoreboard_drained", 8'(expA.size() + expB.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
